// File: rtl/fifo_drain_arbiter.sv
// Round-robin burst drain of NCH first-word-fall-through FIFOs onto one
// valid/ready stream, with a stall timeout that closes a burst short.
module fifo_drain_arbiter #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned DWIDTH  = 16,
  parameter int unsigned LWIDTH  = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         ch_enable,
  input  logic [LWIDTH-1:0]      burst_len,
  input  logic [NCH-1:0]         fifo_empty,
  input  logic [NCH*DWIDTH-1:0]  fifo_dout,
  output logic [NCH-1:0]         fifo_rd_en,
  output logic [DWIDTH-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_ch,
  output logic                   out_first,
  output logic                   out_last,
  output logic                   busy,
  output logic                   short_pulse,
  output logic [LWIDTH-1:0]      short_count
);

  localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned SW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, STALL} state_t;

  state_t            state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     rr_pick;
  logic [GW-1:0]     rr_cand;
  logic              rr_found;
  logic [LWIDTH-1:0] len_latched;
  logic [LWIDTH-1:0] word_cnt;
  logic [SW-1:0]     stall_cnt;
  logic [NCH-1:0]    eligible;
  logic [DWIDTH-1:0] dout_arr [NCH];
  logic              grant_empty;
  logic              xfer;

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign dout_arr[g] = fifo_dout[g*DWIDTH +: DWIDTH];
  end

  assign eligible = ch_enable & ~fifo_empty;

  // Search starts one past the last served channel and wraps modulo NCH.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_cand  = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      rr_cand = GW'((32'(last_grant) + k) % NCH);
      if (!rr_found && eligible[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  // Reset gates the handshake so a burst cut by reset pops nothing more.
  assign grant_empty = fifo_empty[grant];
  assign out_valid   = !reset && (state == DRAIN) && !grant_empty;
  assign out_data    = dout_arr[grant];
  assign xfer        = out_valid && out_ready;
  assign out_first   = out_valid && (word_cnt == '0);
  assign out_last    = out_valid && (word_cnt == len_latched - LWIDTH'(1));
  assign out_ch      = 3'(grant);
  assign busy        = (state != IDLE);

  always_comb begin
    fifo_rd_en        = '0;
    fifo_rd_en[grant] = xfer;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= GW'(NCH - 1);
      len_latched <= '0;
      word_cnt    <= '0;
      stall_cnt   <= '0;
      short_pulse <= 1'b0;
      short_count <= '0;
    end else begin
      short_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rr_found) begin
            grant       <= rr_pick;
            len_latched <= (burst_len == '0) ? LWIDTH'(1) : burst_len;
            word_cnt    <= '0;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (xfer) begin
            word_cnt <= word_cnt + LWIDTH'(1);
            if (out_last) begin
              last_grant <= grant;
              state      <= IDLE;
            end
          end else if (grant_empty) begin
            stall_cnt <= '0;
            state     <= STALL;
          end
        end
        STALL: begin
          if (!grant_empty) begin
            state <= DRAIN;
          end else if (stall_cnt == SW'(TIMEOUT - 1)) begin
            short_pulse <= 1'b1;
            short_count <= word_cnt;
            last_grant  <= grant;
            state       <= IDLE;
          end else begin
            stall_cnt <= stall_cnt + SW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
